id_ex_skid: RTL and testbench

ID_EX_SKID -- requirements
Module: id_ex_skid

---
 rtl/id_ex_skid_pkg.sv | 19 +
 rtl/id_ex_skid.sv | 151 +++++++++++++++
 tb/tb_id_ex_skid.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_skid_pkg.sv
// Shared pipeline defines: default field widths, NOP encodings
// and the skid buffer occupancy states.
package id_ex_skid_pkg;

    localparam int ALUSEL_W_DEF  = 3;
    localparam int ALUOP_W_DEF   = 8;
    localparam int DATA_W_DEF    = 32;
    localparam int REGADDR_W_DEF = 5;

    localparam logic [ALUSEL_W_DEF-1:0] EXE_RES_NOP = '0;
    localparam logic [ALUOP_W_DEF-1:0]  EXE_NOP_OP  = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/id_ex_skid.sv
// ID->EX pipeline register with a one-entry skid so that
// id_ready is a flop with no path from ex_ready.
module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter int ALUSEL_W  = ALUSEL_W_DEF,
    parameter int ALUOP_W   = ALUOP_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REGADDR_W = REGADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [ALUSEL_W-1:0]  id_alusel,
    input  logic [ALUOP_W-1:0]   id_aluop,
    input  logic [DATA_W-1:0]    id_reg1,
    input  logic [DATA_W-1:0]    id_reg2,
    input  logic [REGADDR_W-1:0] id_wd,
    input  logic                 id_wreg,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [ALUSEL_W-1:0]  ex_alusel,
    output logic [ALUOP_W-1:0]   ex_aluop,
    output logic [DATA_W-1:0]    ex_reg1,
    output logic [DATA_W-1:0]    ex_reg2,
    output logic [REGADDR_W-1:0] ex_wd,
    output logic                 ex_wreg
);

    skid_state_e state_q, state_d;
    logic        ready_q;
    logic        in_xfer, out_xfer;
    logic        ld_main_id, ld_main_skid, ld_skid;

    logic [ALUSEL_W-1:0]  m_alusel_q, s_alusel_q;
    logic [ALUOP_W-1:0]   m_aluop_q, s_aluop_q;
    logic [DATA_W-1:0]    m_reg1_q, s_reg1_q;
    logic [DATA_W-1:0]    m_reg2_q, s_reg2_q;
    logic [REGADDR_W-1:0] m_wd_q, s_wd_q;
    logic                 m_wreg_q, s_wreg_q;

    assign ex_valid = (state_q != ST_EMPTY);
    assign id_ready = ready_q;
    assign in_xfer  = id_valid & ready_q;
    assign out_xfer = ex_valid & ex_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (in_xfer) state_d = ST_BUSY;
                ST_BUSY: begin
                    if (in_xfer && !out_xfer)
                        state_d = ST_FULL;
                    else if (!in_xfer && out_xfer)
                        state_d = ST_EMPTY;
                end
                ST_FULL:  if (out_xfer) state_d = ST_BUSY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        ld_main_id   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        unique case (state_q)
            ST_EMPTY: ld_main_id = in_xfer;
            ST_BUSY: begin
                ld_main_id = in_xfer & out_xfer;
                ld_skid    = in_xfer & ~out_xfer;
            end
            ST_FULL:  ld_main_skid = out_xfer;
            default: ;
        endcase
    end

    // Flush loads a NOP so a killed slot never leaks stale fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_alusel_q <= '0;
            m_aluop_q  <= '0;
            m_reg1_q   <= '0;
            m_reg2_q   <= '0;
            m_wd_q     <= '0;
            m_wreg_q   <= 1'b0;
        end else if (flush) begin
            m_alusel_q <= ALUSEL_W'(EXE_RES_NOP);
            m_aluop_q  <= ALUOP_W'(EXE_NOP_OP);
            m_reg1_q   <= '0;
            m_reg2_q   <= '0;
            m_wd_q     <= '0;
            m_wreg_q   <= 1'b0;
        end else if (ld_main_id) begin
            m_alusel_q <= id_alusel;
            m_aluop_q  <= id_aluop;
            m_reg1_q   <= id_reg1;
            m_reg2_q   <= id_reg2;
            m_wd_q     <= id_wd;
            m_wreg_q   <= id_wreg;
        end else if (ld_main_skid) begin
            m_alusel_q <= s_alusel_q;
            m_aluop_q  <= s_aluop_q;
            m_reg1_q   <= s_reg1_q;
            m_reg2_q   <= s_reg2_q;
            m_wd_q     <= s_wd_q;
            m_wreg_q   <= s_wreg_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_alusel_q <= '0;
            s_aluop_q  <= '0;
            s_reg1_q   <= '0;
            s_reg2_q   <= '0;
            s_wd_q     <= '0;
            s_wreg_q   <= 1'b0;
        end else if (ld_skid) begin
            s_alusel_q <= id_alusel;
            s_aluop_q  <= id_aluop;
            s_reg1_q   <= id_reg1;
            s_reg2_q   <= id_reg2;
            s_wd_q     <= id_wd;
            s_wreg_q   <= id_wreg;
        end
    end

    assign ex_alusel = m_alusel_q;
    assign ex_aluop  = m_aluop_q;
    assign ex_reg1   = m_reg1_q;
    assign ex_reg2   = m_reg2_q;
    assign ex_wd     = m_wd_q;
    assign ex_wreg   = m_wreg_q & ex_valid;

endmodule

// File: tb/tb_id_ex_skid.sv
// Scoreboard bench for id_ex_skid: a FIFO-of-depth-2 model
// predicts handshakes and the in-order output stream.
module tb_id_ex_skid;

    typedef struct packed {
        logic [2:0]  alusel;
        logic [7:0]  aluop;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst, flush, id_valid, id_ready, ex_valid, ex_ready;
    instr_t id_pkt, ex_pkt;
    logic [2:0]  ex_alusel;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_reg1, ex_reg2;
    logic [4:0]  ex_wd;
    logic        ex_wreg;

    instr_t q[$];
    int     checks = 0;
    int     errors = 0;
    int     n_out = 0;
    bit     nop_pending = 0;

    always #5 clk = ~clk;

    assign ex_pkt = '{ex_alusel, ex_aluop, ex_reg1, ex_reg2, ex_wd, ex_wreg};

    id_ex_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_alusel(id_pkt.alusel), .id_aluop(id_pkt.aluop),
        .id_reg1(id_pkt.reg1), .id_reg2(id_pkt.reg2),
        .id_wd(id_pkt.wd), .id_wreg(id_pkt.wreg),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic instr_t rnd_instr();
        instr_t t;
        t.alusel = 3'($urandom);
        t.aluop  = 8'($urandom);
        t.reg1   = $urandom;
        t.reg2   = $urandom;
        t.wd     = 5'($urandom);
        t.wreg   = 1'($urandom);
        return t;
    endfunction

    // Monitor: model is a FIFO holding at most two instructions.
    always @(negedge clk) begin
        bit acc, out;
        if (rst) begin
            q.delete();
            nop_pending = 0;
        end else begin
            chk("id_ready", 64'(id_ready), 64'(q.size() < 2));
            chk("ex_valid", 64'(ex_valid), 64'(q.size() > 0));
            if (!ex_valid)
                chk("wreg_idle", 64'(ex_wreg), 64'd0);
            if (nop_pending) begin
                chk("nop_aluop", 64'(ex_aluop), 64'd0);
                chk("nop_alusel", 64'(ex_alusel), 64'd0);
                chk("nop_wd", 64'(ex_wd), 64'd0);
            end
            if (ex_valid && q.size() > 0)
                chk("payload", 64'(ex_pkt), 64'(q[0]));
            nop_pending = flush;
            acc = id_valid && (q.size() < 2);
            out = ex_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (out) begin
                    void'(q.pop_front());
                    n_out++;
                end
                if (acc) q.push_back(id_pkt);
            end
        end
    end

    initial begin
        instr_t a, b, c;
        int base;
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0;
        ex_ready = 1'b0; id_pkt = '0;
        #1;
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_id_ready", 64'(id_ready), 64'd1);
        chk("rst_payload", 64'(ex_pkt), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single instruction, one-cycle latency
        a = '{3'd1, 8'h21, 32'd5, 32'd7, 5'd3, 1'b1};
        id_valid = 1'b1; ex_ready = 1'b1; id_pkt = a;
        @(posedge clk); #1;
        id_valid = 1'b0;
        chk("lat_valid", 64'(ex_valid), 64'd1);
        chk("lat_payload", 64'(ex_pkt), 64'(a));
        chk("lat_ready", 64'(id_ready), 64'd1);
        @(posedge clk); #1;

        // Backpressure: A held, B in skid
        a = rnd_instr(); b = rnd_instr();
        ex_ready = 1'b0; id_valid = 1'b1; id_pkt = a;
        @(posedge clk); #1;
        id_pkt = b;
        @(posedge clk); #1;
        id_valid = 1'b0;
        chk("bp_ready", 64'(id_ready), 64'd0);
        chk("bp_hold_a", 64'(ex_pkt), 64'(a));
        @(posedge clk); #1;
        chk("bp_stable_a", 64'(ex_pkt), 64'(a));
        ex_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_b", 64'(ex_pkt), 64'(b));
        chk("bp_b_valid", 64'(ex_valid), 64'd1);
        @(posedge clk); #1;
        chk("bp_drain_ready", 64'(id_ready), 64'd1);
        chk("bp_drain_valid", 64'(ex_valid), 64'd0);

        // 16-deep back-to-back stream
        base = n_out;
        id_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            id_pkt = rnd_instr();
            @(posedge clk); #1;
        end
        id_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream_count", 64'(n_out - base), 64'd16);

        // Flush while FULL with a new input offered
        ex_ready = 1'b0; id_valid = 1'b1;
        id_pkt = rnd_instr();
        @(posedge clk); #1;
        id_pkt = rnd_instr();
        @(posedge clk); #1;
        c = rnd_instr();
        c.wreg = 1'b1;
        id_pkt = c; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        chk("fl_valid", 64'(ex_valid), 64'd0);
        chk("fl_wreg", 64'(ex_wreg), 64'd0);
        chk("fl_aluop", 64'(ex_aluop), 64'd0);
        chk("fl_ready", 64'(id_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic with occasional flush
        for (int i = 0; i < 1000; i++) begin
            id_valid = 1'($urandom);
            ex_ready = 1'($urandom);
            flush    = ($urandom_range(0, 49) == 0);
            id_pkt   = rnd_instr();
            @(posedge clk); #1;
        end
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;

        // Asynchronous reset mid-cycle while FULL
        id_valid = 1'b1; id_pkt = rnd_instr();
        @(posedge clk); #1;
        id_pkt = rnd_instr();
        @(posedge clk); #1;
        id_pkt = rnd_instr();
        @(posedge clk); #1;
        id_valid = 1'b0;
        chk("ar_full", 64'(id_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(ex_valid), 64'd0);
        chk("ar_wreg", 64'(ex_wreg), 64'd0);
        chk("ar_payload", 64'(ex_pkt), 64'd0);
        chk("ar_ready", 64'(id_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0; ex_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 64'(ex_valid), 64'd0);
        chk("post_rst_ready", 64'(id_ready), 64'd1);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
